// File: rtl/int8_conv_postproc_unit.sv
// Per-pixel INT8 conv post-processing: MAC, LeakyReLU and requantize lanes, each 1-cycle latency.
// Optional build macro MAC_SATURATE_EN clamps the MAC sum instead of letting it wrap.
module int8_conv_postproc_unit #(
  parameter int unsigned SCALE_Q     = 16,
  parameter int unsigned LEAKY_SHIFT = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mac_valid,
  input  logic [7:0]  mac_weight,
  input  logic [7:0]  mac_activation,
  input  logic [31:0] mac_acc_in,
  output logic [31:0] mac_acc_out,
  output logic        mac_done,
  input  logic        act_valid,
  input  logic [31:0] act_x,
  output logic [31:0] act_y,
  output logic        act_done,
  input  logic        req_valid,
  input  logic [31:0] req_acc,
  input  logic [15:0] req_scale,
  output logic [7:0]  req_out,
  output logic        req_done
);

  localparam logic [48:0] RoundConst = (SCALE_Q == 0) ? 49'd0 : (49'd1 << (SCALE_Q - 1));

  logic [31:0] mac_acc_q, act_y_q;
  logic [7:0]  req_out_q;
  logic        mac_done_q, act_done_q, req_done_q;

  // MAC lane: operands sign-extended to 16 bits so the product is exact modulo 2^16
  logic [15:0] mac_prod;
  logic [31:0] mac_sum;

  assign mac_prod = {{8{mac_weight[7]}}, mac_weight} * {{8{mac_activation[7]}}, mac_activation};

`ifdef MAC_SATURATE_EN
  logic [32:0] mac_wide;

  assign mac_wide = {mac_acc_in[31], mac_acc_in} + {{17{mac_prod[15]}}, mac_prod};

  always_comb begin
    mac_sum = mac_wide[31:0];
    if (mac_wide[32] != mac_wide[31]) begin
      mac_sum = mac_wide[32] ? 32'h8000_0000 : 32'h7fff_ffff;
    end
  end
`else
  assign mac_sum = mac_acc_in + {{16{mac_prod[15]}}, mac_prod};
`endif

  // Activation lane
  logic signed [31:0] act_shifted;
  logic [31:0]        act_next;

  assign act_shifted = $signed(act_x) >>> LEAKY_SHIFT;
  assign act_next    = act_x[31] ? act_shifted : act_x;

  // Requantize lane: full 49-bit product, two's-complement mod 2^49 is exact here
  logic [48:0]        req_prod, req_round;
  logic signed [48:0] req_shift;
  logic [7:0]         req_sat;

  assign req_prod  = {{17{req_acc[31]}}, req_acc} * {33'd0, req_scale};
  assign req_round = req_prod + RoundConst;
  assign req_shift = $signed(req_round) >>> SCALE_Q;

  always_comb begin
    req_sat = req_shift[7:0];
    if (req_shift > 49'sd127) begin
      req_sat = 8'h7f;
    end else if (req_shift < -49'sd128) begin
      req_sat = 8'h80;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mac_acc_q  <= '0;
      mac_done_q <= 1'b0;
      act_y_q    <= '0;
      act_done_q <= 1'b0;
      req_out_q  <= '0;
      req_done_q <= 1'b0;
    end else begin
      mac_done_q <= mac_valid;
      act_done_q <= act_valid;
      req_done_q <= req_valid;
      if (mac_valid) mac_acc_q <= mac_sum;
      if (act_valid) act_y_q <= act_next;
      if (req_valid) req_out_q <= req_sat;
    end
  end

  assign mac_acc_out = mac_acc_q;
  assign mac_done    = mac_done_q;
  assign act_y       = act_y_q;
  assign act_done    = act_done_q;
  assign req_out     = req_out_q;
  assign req_done    = req_done_q;

endmodule

// File: tb/tb_int8_conv_postproc_unit.sv
// Self-checking bench for int8_conv_postproc_unit: directed cases plus randomized traffic
// checked against an arithmetic reference model.
module tb_int8_conv_postproc_unit;

  localparam int unsigned SQ = 16;
  localparam int unsigned LS = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        mac_valid;
  logic [7:0]  mac_weight, mac_activation;
  logic [31:0] mac_acc_in, mac_acc_out;
  logic        mac_done;
  logic        act_valid;
  logic [31:0] act_x, act_y;
  logic        act_done;
  logic        req_valid;
  logic [31:0] req_acc;
  logic [15:0] req_scale;
  logic [7:0]  req_out;
  logic        req_done;

  int checks = 0;
  int failures = 0;

  int8_conv_postproc_unit #(
    .SCALE_Q     (SQ),
    .LEAKY_SHIFT (LS)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .mac_valid      (mac_valid),
    .mac_weight     (mac_weight),
    .mac_activation (mac_activation),
    .mac_acc_in     (mac_acc_in),
    .mac_acc_out    (mac_acc_out),
    .mac_done       (mac_done),
    .act_valid      (act_valid),
    .act_x          (act_x),
    .act_y          (act_y),
    .act_done       (act_done),
    .req_valid      (req_valid),
    .req_acc        (req_acc),
    .req_scale      (req_scale),
    .req_out        (req_out),
    .req_done       (req_done)
  );

  always #5 clk = ~clk;

  // ---------------- reference model (plain integer arithmetic) ----------------
  function automatic longint floor_div_pow2(longint v, int unsigned sh);
    longint d = longint'(1) << sh;
    longint q = v / d;
    if ((v % d) != 0 && v < 0) q = q - 1;
    return q;
  endfunction

  function automatic logic [31:0] ref_mac(logic [31:0] acc, logic [7:0] w, logic [7:0] a);
    longint s = longint'($signed(acc)) + longint'($signed(w)) * longint'($signed(a));
`ifdef MAC_SATURATE_EN
    if (s > 64'sd2147483647) s = 64'sd2147483647;
    if (s < -64'sd2147483648) s = -64'sd2147483648;
`endif
    return s[31:0];
  endfunction

  function automatic logic [31:0] ref_leaky(logic [31:0] x);
    longint v = longint'($signed(x));
    if (v >= 0) return x;
    v = floor_div_pow2(v, LS);
    return v[31:0];
  endfunction

  function automatic logic [7:0] ref_req(logic [31:0] acc, logic [15:0] scale);
    longint p = longint'($signed(acc)) * longint'(scale);
    longint r = floor_div_pow2(p + (longint'(1) << (SQ - 1)), SQ);
    if (r > 127) r = 127;
    if (r < -128) r = -128;
    return r[7:0];
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    mac_valid = 0; mac_weight = 0; mac_activation = 0; mac_acc_in = 0;
    act_valid = 0; act_x = 0;
    req_valid = 0; req_acc = 0; req_scale = 0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    rst = 1;
    idle_inputs();
    repeat (3) tick();
    checks += 6;
    if (mac_acc_out !== 32'd0) begin failures++; $display("FAIL reset_mac_acc_out got=%0h exp=0", mac_acc_out); end
    if (mac_done !== 1'b0) begin failures++; $display("FAIL reset_mac_done got=%b exp=0", mac_done); end
    if (act_y !== 32'd0) begin failures++; $display("FAIL reset_act_y got=%0h exp=0", act_y); end
    if (act_done !== 1'b0) begin failures++; $display("FAIL reset_act_done got=%b exp=0", act_done); end
    if (req_out !== 8'd0) begin failures++; $display("FAIL reset_req_out got=%0h exp=0", req_out); end
    if (req_done !== 1'b0) begin failures++; $display("FAIL reset_req_done got=%b exp=0", req_done); end
    rst = 0;
  endtask

  task automatic test_mac_single;
    mac_valid = 1; mac_weight = 8'h80; mac_activation = 8'h80; mac_acc_in = 0;
    tick();
    checks += 4;
    if (mac_acc_out !== 32'd16384) begin failures++; $display("FAIL mac_single_result got=%0d exp=16384", $signed(mac_acc_out)); end
    if (mac_done !== 1'b1) begin failures++; $display("FAIL mac_single_done got=%b exp=1", mac_done); end
    mac_valid = 0;
    tick();
    if (mac_done !== 1'b0) begin failures++; $display("FAIL mac_single_done_clear got=%b exp=0", mac_done); end
    if (mac_acc_out !== 32'd16384) begin failures++; $display("FAIL mac_single_hold got=%0d exp=16384", $signed(mac_acc_out)); end
    // 127 * -128 from zero
    mac_valid = 1; mac_weight = 8'd127; mac_activation = 8'h80; mac_acc_in = 0;
    tick();
    mac_valid = 0;
    checks++;
    if (mac_acc_out !== -32'sd16256) begin failures++; $display("FAIL mac_extreme_neg got=%0d exp=-16256", $signed(mac_acc_out)); end
  endtask

  task automatic test_mac_chain;
    int bad_done = 0;
    mac_acc_in = 0; mac_weight = 8'd127; mac_activation = 8'd127; mac_valid = 1;
    for (int i = 0; i < 1152; i++) begin
      tick();
      if (mac_done !== 1'b1) bad_done++;
      mac_acc_in = mac_acc_out;
    end
    mac_valid = 0;
    checks += 2;
    if (mac_acc_out !== 32'd18580608) begin failures++; $display("FAIL mac_chain_final got=%0d exp=18580608", $signed(mac_acc_out)); end
    if (bad_done != 0) begin failures++; $display("FAIL mac_chain_done_low_cycles got=%0d exp=0", bad_done); end
    tick();
  endtask

  task automatic test_mac_alternating;
    logic [31:0] model = 0;
    mac_acc_in = 0; mac_valid = 1;
    for (int i = 0; i < 40; i++) begin
      mac_weight     = (i % 2 == 0) ? 8'd127 : 8'hff;
      mac_activation = (i % 2 == 0) ? 8'h80 : 8'hff;
      model = ref_mac(model, mac_weight, mac_activation);
      tick();
      checks++;
      if (mac_acc_out !== model) begin failures++; $display("FAIL mac_alt step=%0d got=%0d exp=%0d", i, $signed(mac_acc_out), $signed(model)); end
      mac_acc_in = mac_acc_out;
    end
    mac_valid = 0;
    tick();
  endtask

  task automatic test_leaky;
    logic [31:0] xs [7] = '{32'd100, 32'd0, -32'sd100, -32'sd1, -32'sd8, 32'h8000_0000, 32'h7fff_ffff};
    logic [31:0] ys [7] = '{32'd100, 32'd0, -32'sd13, -32'sd1, -32'sd1, -32'sd268435456, 32'h7fff_ffff};
    for (int i = 0; i < 7; i++) begin
      act_valid = 1; act_x = xs[i];
      tick();
      checks += 4;
      if (act_y !== ys[i]) begin failures++; $display("FAIL leaky x=%0d got=%0d exp=%0d", $signed(xs[i]), $signed(act_y), $signed(ys[i])); end
      if (act_done !== 1'b1) begin failures++; $display("FAIL leaky_done x=%0d got=%b exp=1", $signed(xs[i]), act_done); end
      act_valid = 0; act_x = $urandom;
      tick();
      if (act_done !== 1'b0) begin failures++; $display("FAIL leaky_done_pulse x=%0d got=%b exp=0", $signed(xs[i]), act_done); end
      if (act_y !== ys[i]) begin failures++; $display("FAIL leaky_hold x=%0d got=%0d exp=%0d", $signed(xs[i]), $signed(act_y), $signed(ys[i])); end
    end
  endtask

  task automatic test_requant;
    logic [31:0] accs [8] = '{32'd10000, -32'sd10000, 32'd200000, -32'sd200000, 32'd0, 32'd1,
                              32'd12345, 32'h8000_0000};
    logic [15:0] scs  [8] = '{16'd655, 16'd655, 16'd655, 16'd655, 16'd655, 16'd65535, 16'd0, 16'd1};
    logic [7:0]  exps [8] = '{8'd100, 8'h9c, 8'd127, 8'h80, 8'd0, 8'd1, 8'd0, 8'h80};
    for (int i = 0; i < 8; i++) begin
      req_valid = 1; req_acc = accs[i]; req_scale = scs[i];
      tick();
      checks += 2;
      if (req_out !== exps[i]) begin failures++; $display("FAIL requant acc=%0d scale=%0d got=%0d exp=%0d", $signed(accs[i]), scs[i], $signed(req_out), $signed(exps[i])); end
      if (req_done !== 1'b1) begin failures++; $display("FAIL requant_done acc=%0d got=%b exp=1", $signed(accs[i]), req_done); end
    end
    req_valid = 0;
    tick();
    checks++;
    if (req_done !== 1'b0) begin failures++; $display("FAIL requant_done_clear got=%b exp=0", req_done); end
  endtask

  task automatic test_reset_mid;
    mac_valid = 1; mac_weight = 8'd5; mac_activation = 8'd7; mac_acc_in = 32'd1000;
    act_valid = 1; act_x = 32'd77;
    req_valid = 1; req_acc = 32'd10000; req_scale = 16'd655;
    rst = 1;
    tick();
    checks += 6;
    if (mac_acc_out !== 32'd0) begin failures++; $display("FAIL rstmid_mac_acc_out got=%0h exp=0", mac_acc_out); end
    if (mac_done !== 1'b0) begin failures++; $display("FAIL rstmid_mac_done got=%b exp=0", mac_done); end
    if (act_y !== 32'd0) begin failures++; $display("FAIL rstmid_act_y got=%0h exp=0", act_y); end
    if (act_done !== 1'b0) begin failures++; $display("FAIL rstmid_act_done got=%b exp=0", act_done); end
    if (req_out !== 8'd0) begin failures++; $display("FAIL rstmid_req_out got=%0h exp=0", req_out); end
    if (req_done !== 1'b0) begin failures++; $display("FAIL rstmid_req_done got=%b exp=0", req_done); end
    rst = 0;
    idle_inputs();
    tick();
    checks++;
    if ({mac_done, act_done, req_done} !== 3'b000) begin failures++; $display("FAIL rstmid_stale_done got=%b exp=000", {mac_done, act_done, req_done}); end
    mac_valid = 1; mac_weight = 8'd5; mac_activation = 8'd7; mac_acc_in = 32'd1000;
    tick();
    mac_valid = 0;
    checks += 2;
    if (mac_acc_out !== 32'd1035) begin failures++; $display("FAIL rstmid_resume got=%0d exp=1035", $signed(mac_acc_out)); end
    if ({mac_done, act_done, req_done} !== 3'b100) begin failures++; $display("FAIL rstmid_resume_done got=%b exp=100", {mac_done, act_done, req_done}); end
  endtask

  task automatic test_overflow;
    logic [31:0] exp_pos, exp_neg;
`ifdef MAC_SATURATE_EN
    exp_pos = 32'h7fff_ffff;
    exp_neg = 32'h8000_0000;
`else
    exp_pos = -32'sd2147467567;
    exp_neg = 32'd2147467440;
`endif
    mac_valid = 1; mac_weight = 8'd127; mac_activation = 8'd127; mac_acc_in = 32'd2147483600;
    tick();
    checks += 2;
    if (mac_acc_out !== exp_pos) begin failures++; $display("FAIL overflow_pos got=%0d exp=%0d", $signed(mac_acc_out), $signed(exp_pos)); end
    mac_weight = 8'd127; mac_activation = 8'h80; mac_acc_in = -32'sd2147483600;
    tick();
    mac_valid = 0;
    if (mac_acc_out !== exp_neg) begin failures++; $display("FAIL overflow_neg got=%0d exp=%0d", $signed(mac_acc_out), $signed(exp_neg)); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] e_mac, e_act;
    logic [7:0]  e_req;
    logic        v_mac, v_act, v_req;
    e_mac = mac_acc_out; e_act = act_y; e_req = req_out;
    for (int i = 0; i < 300; i++) begin
      v_mac = ($urandom_range(0, 3) != 0);
      v_act = ($urandom_range(0, 3) != 0);
      v_req = ($urandom_range(0, 3) != 0);
      mac_valid = v_mac; mac_weight = 8'($urandom); mac_activation = 8'($urandom);
      mac_acc_in = ($urandom_range(0, 1) != 0) ? $urandom : 32'($signed(20'($urandom)));
      act_valid = v_act; act_x = $urandom;
      req_valid = v_req;
      req_acc = ($urandom_range(0, 1) != 0) ? $urandom : 32'($signed(22'($urandom)));
      req_scale = ($urandom_range(0, 1) != 0) ? 16'($urandom) : 16'($urandom_range(0, 2000));
      if (v_mac) e_mac = ref_mac(mac_acc_in, mac_weight, mac_activation);
      if (v_act) e_act = ref_leaky(act_x);
      if (v_req) e_req = ref_req(req_acc, req_scale);
      tick();
      checks += 4;
      if (mac_acc_out !== e_mac) begin failures++; $display("FAIL rand_mac i=%0d got=%0d exp=%0d", i, $signed(mac_acc_out), $signed(e_mac)); end
      if (act_y !== e_act) begin failures++; $display("FAIL rand_act i=%0d got=%0d exp=%0d", i, $signed(act_y), $signed(e_act)); end
      if (req_out !== e_req) begin failures++; $display("FAIL rand_req i=%0d got=%0d exp=%0d", i, $signed(req_out), $signed(e_req)); end
      if ({mac_done, act_done, req_done} !== {v_mac, v_act, v_req}) begin
        failures++;
        $display("FAIL rand_done i=%0d got=%b exp=%b", i, {mac_done, act_done, req_done}, {v_mac, v_act, v_req});
      end
    end
    idle_inputs();
    tick();
  endtask

  initial begin
    test_reset();
    test_mac_single();
    test_mac_chain();
    test_mac_alternating();
    test_leaky();
    test_requant();
    test_reset_mid();
    test_overflow();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
